// File: rtl/sly_pkg.sv
// Shared constants for the button poll path: colour codes, event word layout, MMIO address.
package sly_pkg;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned EV_W        = 32;
  localparam int unsigned TS_W        = 16;
  localparam int unsigned COLOR_W     = 2;

  typedef enum logic [COLOR_W-1:0] {
    COLOR_RED    = 2'd0,
    COLOR_BLUE   = 2'd1,
    COLOR_GREEN  = 2'd2,
    COLOR_YELLOW = 2'd3
  } color_e;

  localparam int unsigned EV_COLOR_LSB = 0;
  localparam int unsigned EV_VALID_BIT = 2;
  localparam int unsigned EV_TS_LSB    = 16;

  localparam logic [31:0] ADDR_BUTTON = 32'd7;

  // Event word as seen by software: colour, valid flag, optional timestamp.
  function automatic logic [EV_W-1:0] make_event(input color_e color, input logic [TS_W-1:0] ts);
    logic [EV_W-1:0] ev;
    ev                            = '0;
    ev[EV_COLOR_LSB +: COLOR_W]   = color;
    ev[EV_VALID_BIT]              = 1'b1;
    ev[EV_TS_LSB +: TS_W]         = ts;
    return ev;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw button input.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_s;

  assign in_s = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (in_s != stable) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= in_s;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Debounced button presses queued as colour events for the CPU poll at data word 7.
// Optional BUTTON_QUEUE_TIMESTAMP_EN stores a tick count in event bits [31:16].
module button_event_queue
  import sly_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned MS_CYCLES       = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   red_button,
  input  logic                   blue_button,
  input  logic                   green_button,
  input  logic                   yellow_button,
  input  logic                   pop,
  output logic [EV_W-1:0]        event_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 1 || MS_CYCLES < 1) begin : g_bad_params
    $error("button_event_queue: invalid parameters");
  end

  logic [NUM_BUTTONS-1:0] raw;
  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] stable_q;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] grant;
  logic [NUM_BUTTONS-1:0] clear_mask;
  color_e                 grant_color;

  logic [EV_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_q;
  logic             empty;
  logic             full;
  logic             pop_fire;
  logic             wr_en;
  logic [TS_W-1:0]  ts;

  assign raw = {yellow_button, green_button, blue_button, red_button};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_debounce
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock (clock),
      .reset (reset),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  assign rise = stable & ~stable_q;

  // Fixed priority: lowest index (red) wins.
  always_comb begin
    grant       = '0;
    grant_color = COLOR_RED;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant       = '0;
        grant[i]    = 1'b1;
        grant_color = color_e'(COLOR_W'(i));
      end
    end
  end

  assign empty    = (count == CNT_W'(0));
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_fire = pop & ~pop_q & ~empty;
  // A full queue still accepts a write when the same edge frees a slot.
  assign wr_en      = (|pending) & (~full | pop_fire);
  assign clear_mask = wr_en ? grant : '0;

  assign event_out = empty ? '0 : mem[rd_ptr];

`ifdef BUTTON_QUEUE_TIMESTAMP_EN
  localparam int unsigned PRESC_W = $clog2(MS_CYCLES + 1);

  logic [PRESC_W-1:0] presc_q;
  logic [TS_W-1:0]    tick_q;

  // Ticks since the previous enqueue, saturating; both counters restart on each write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else if (wr_en) begin
      presc_q <= '0;
      tick_q  <= '0;
    end else if (presc_q == PRESC_W'(MS_CYCLES - 1)) begin
      presc_q <= '0;
      if (tick_q != '1) begin
        tick_q <= tick_q + TS_W'(1);
      end
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  assign ts = tick_q;
`else
  assign ts = '0;
`endif

  // Press capture, overflow flag and FIFO pointer/count state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      pop_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      stable_q <= stable;
      pop_q    <= pop;
      pending  <= (pending & ~clear_mask) | (rise & ~pending);
      if (|(rise & pending)) begin
        overflow <= 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= make_event(grant_color, ts);
    end
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed self-checking bench for button_event_queue (DEBOUNCE_CYCLES=4, DEPTH=4, MS_CYCLES=10).
module tb_button_event_queue;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MS    = 10;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        red    = 1'b0;
  logic        blue   = 1'b0;
  logic        green  = 1'b0;
  logic        yellow = 1'b0;
  logic        pop    = 1'b0;
  logic [31:0] event_out;
  logic [2:0]  count;
  logic        overflow;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc;
  int unsigned n_red;
  logic [15:0] ts_red;
  logic [15:0] ts_blue;

  always #5 clock = ~clock;

  // Edges since reset release, used to predict the timestamp field.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  button_event_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .DEPTH          (DEPTH),
    .MS_CYCLES      (MS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .red_button   (red),
    .blue_button  (blue),
    .green_button (green),
    .yellow_button(yellow),
    .pop          (pop),
    .event_out    (event_out),
    .count        (count),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_buttons(input logic [3:0] m);
    {yellow, green, blue, red} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_buttons(m);
    cycles(12);
    set_buttons(4'b0000);
    cycles(12);
  endtask

  task automatic pop_read(input string tag, input logic [31:0] exp);
    check(tag, event_out, exp);
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
    cycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(2);
    check("rst_event", event_out, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Single red press: exact latency DEB+4 edges.
    red = 1'b1;
    cycles(7);
    check("lat_minus1", event_out, 32'h0);
    cycles(1);
    check("lat_event", event_out, 32'h4);
    check("lat_count", 32'(count), 32'd1);
    cycles(12);
    red = 1'b0;
    cycles(12);
    pop_read("red_head", 32'h4);
    check("pop_empty_event", event_out, 32'h0);
    check("pop_empty_count", 32'(count), 32'd0);

    // Glitch shorter than the debounce window.
    blue = 1'b1;
    cycles(3);
    blue = 1'b0;
    cycles(15);
    check("glitch_count", 32'(count), 32'd0);
    check("glitch_event", event_out, 32'h0);

    // Red, green, yellow together: written on consecutive edges in priority order.
    set_buttons(4'b1101);
    cycles(8);
    check("multi_c1", 32'(count), 32'd1);
    check("multi_head", event_out, 32'h4);
    cycles(1);
    check("multi_c2", 32'(count), 32'd2);
    cycles(1);
    check("multi_c3", 32'(count), 32'd3);
    cycles(10);
    set_buttons(4'b0000);
    cycles(12);
    pop_read("multi_pop0", 32'h4);
    pop_read("multi_pop1", 32'h6);
    pop_read("multi_pop2", 32'h7);
    check("multi_drained", 32'(count), 32'd0);

    // Fill the queue, fifth press waits in pending, then overflow on a repeat colour.
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    press(4'b0001);
    check("full_count", 32'(count), 32'd4);
    check("full_no_ovf", 32'(overflow), 32'd0);
    pop_read("full_pop_red", 32'h4);
    check("full_refill", 32'(count), 32'd4);
    check("full_head_blue", event_out, 32'h5);
    press(4'b0010);
    check("blue_pending_no_ovf", 32'(overflow), 32'd0);
    press(4'b0010);
    check("ovf_set", 32'(overflow), 32'd1);
    pop_read("drain0", 32'h5);
    pop_read("drain1", 32'h6);
    pop_read("drain2", 32'h7);
    pop_read("drain3", 32'h4);
    pop_read("drain4", 32'h5);
    check("drain_count", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Pop edge on an empty queue coinciding with the write edge.
    red = 1'b1;
    cycles(7);
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
    check("empty_popwr_count", 32'(count), 32'd1);
    check("empty_popwr_event", event_out, 32'h4);
    cycles(12);
    red = 1'b0;
    cycles(12);
    pop_read("empty_popwr_read", 32'h4);

    // Pop held for several cycles removes exactly one event.
    press(4'b0011);
    check("hold_pre_count", 32'(count), 32'd2);
    pop = 1'b1;
    cycles(5);
    pop = 1'b0;
    cycles(1);
    check("hold_count", 32'(count), 32'd1);
    check("hold_head", event_out, 32'h5);

    // Asynchronous reset mid-queue.
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_event", event_out, 32'h0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    cycles(2);
    reset = 1'b0;

    // Timestamp: red after a delay from reset, blue 35 cycles after red.
    cycles(30);
    red = 1'b1;
    cycles(8);
    n_red = cyc;
`ifdef BUTTON_QUEUE_TIMESTAMP_EN
    ts_red  = 16'((n_red - 1) / MS);
    ts_blue = 16'd3;
`else
    ts_red  = 16'd0;
    ts_blue = 16'd0;
`endif
    check("ts_red_live", event_out, {ts_red, 16'h0004});
    cycles(4);
    red = 1'b0;
    cycles(23);
    blue = 1'b1;
    cycles(12);
    blue = 1'b0;
    cycles(12);
    check("ts_count", 32'(count), 32'd2);
    pop_read("ts_red", {ts_red, 16'h0004});
    pop_read("ts_blue", {ts_blue, 16'h0005});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Input stage ahead of the button-poll read path at data address 7. It synchronizes and debounces the four game buttons, turns each clean press into a colour event, and holds the events in a small FIFO. The processor drains the FIFO one event per `lw` from address 7. Presses that occur while the CPU is busy (playing audio, flashing LEDs, driving servos) are therefore kept, not lost.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `MS_CYCLES`, default 50000: clock cycles per timestamp tick. Used only with the timestamp feature.

Ports:
- `clock` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high; clears all state.
- `red_button`, `blue_button`, `green_button`, `yellow_button` in 1 each: raw asynchronous inputs, active-high.
- `pop` in 1: level, high while the CPU addresses data word 7.
- `event_out` out 32: head event, show-ahead. Reads 0 when the queue is empty.
- `count` out $clog2(DEPTH)+1: number of queued events.
- `overflow` out 1: sticky; a press was dropped.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer.
- **Debouncer:** one per button.
  - Holds a `stable` level (reset 0) and a counter (reset 0).
  - When the synchronized input differs from `stable`, the counter increments. Otherwise it clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, `stable` takes the input value and the counter clears.
- **Press detection:** a 0→1 transition of `stable` sets that button's `pending` bit.
  - If `pending` is already set, the new press is dropped and `overflow` is set.
- **Arbiter:** each cycle, the lowest-index set `pending` bit is written to the FIFO if the FIFO is not full, and that bit is cleared.
  - Priority order: red(0), blue(1), green(2), yellow(3).
  - At most one write per cycle.
- **Event word:**
  - bits [1:0] = colour code: 00 red, 01 blue, 10 green, 11 yellow.
  - bit 2 = valid (1 for any queued event).
  - bits [15:3] = 0.
  - bits [31:16] = 0 unless the timestamp feature is compiled in.
- **Pop:** a pop occurs on the rising edge of `pop`, i.e. `pop & ~pop_q`, so one `lw` that holds the address for several cycles removes exactly one event.
  - The current `event_out` is the value the CPU reads; the head advances at the end of that cycle.
  - A pop on an empty queue is ignored.
- **Full:** writes stall and `pending` bits hold. No data is lost until a second press of the same colour arrives.
- **Simultaneous write and pop:**
  - Full: both occur and `count` is unchanged.
  - Empty: the pop is ignored and the write lands, so `count` becomes 1.
- **Pointers:** read/write pointers wrap modulo `DEPTH`. `count` saturates at `DEPTH` by construction.
- **Clearing `overflow`:** only by `reset`.

## Timing
- Reset values: `event_out`=0, `count`=0, `overflow`=0. All `stable`, `pending`, counters, pointers and `pop_q` are cleared.
- Press latency into an empty queue with no contention is exactly `DEBOUNCE_CYCLES`+4 clock edges from the first edge sampling the raw input high to `event_out` showing the event:
  - 2 edges synchronizer;
  - `DEBOUNCE_CYCLES` edges debounce;
  - 1 edge `pending`;
  - 1 edge FIFO write.
- Contention: a pending event waits one extra cycle per higher-priority event written ahead of it.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- Release is debounced the same way but enqueues nothing.
- `reset` asserted mid-debounce or mid-queue discards everything, asynchronously.

## Configuration
- Macro: `BUTTON_QUEUE_TIMESTAMP_EN`.
- **Defined:**
  - A 16-bit tick counter advances once every `MS_CYCLES` cycles and saturates at 0xFFFF.
  - On each FIFO write, the counter value is stored in bits [31:16] of that event, and the counter clears to 0.
  - The software uses this field to measure reaction time between presses.
  - The counter resets to 0.
- **Undefined:** bits [31:16] are constant 0, and no tick counter or prescaler is built.

## Structure
- Shared package `sly_pkg`:
  - colour code constants `COLOR_RED`, `COLOR_BLUE`, `COLOR_GREEN`, `COLOR_YELLOW`;
  - event field positions `EV_COLOR_LSB`, `EV_VALID_BIT`, `EV_TS_LSB`;
  - MMIO address constant `ADDR_BUTTON` = 7.
- Sub-module `button_debounce`: synchronizer, counter and `stable` output, parameterized by `DEBOUNCE_CYCLES`, instantiated four times.
- FIFO, arbiter and pop-edge logic stay in the top module.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DEPTH`=4, `MS_CYCLES`=10.
- Red held high for 20 cycles, queue empty → `event_out`=32'h4 exactly 8 edges after the first high sample; `count`=1; pop → `event_out`=0, `count`=0.
- Blue high for 3 cycles, then low → no event; `count` stays 0.
- Red, green and yellow rise in the same cycle → events 4, 6, 7 written on consecutive cycles; three pops read 4, 6, 7 in that order.
- Five distinct presses (r, b, g, y, r) with no pops → `count`=4, fifth red held in `pending`. One pop → red enqueued, `count` back to 4. A further blue press while blue is still pending → `overflow`=1.
- `pop` held high for 5 cycles with 2 events queued → exactly one event removed; `count`=1.
- Timestamp on: press red, wait 35 cycles, press blue → red event bits [31:16] = ticks since reset, blue event bits [31:16]=3.
- Reset asserted mid-queue: `count`=0, `event_out`=0 and `overflow`=0 within the same cycle.
